// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin on ties; otherwise m0 has fixed priority.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic [AW-1:0]   m0_addr,
    input  logic            m0_we,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wmask,
    output logic            m0_gnt,
    output logic            m0_done,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic [AW-1:0]   m1_addr,
    input  logic            m1_we,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wmask,
    output logic            m1_gnt,
    output logic            m1_done,
    output logic [DW-1:0]   m1_rdata,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_wmask,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);
    // state | meaning
    // IDLE  | waiting for a request; grant pulses here
    // ISSUE | captured request on the memory port; write strobe here
    // WAIT  | read in flight for READ_LATENCY cycles
    // DONE  | owner's done pulse, read data in rdata_q
    localparam int LW = $clog2(READ_LATENCY + 1);

    if (READ_LATENCY < 1) begin : g_cfg_err
        $error("mem_port_arbiter: READ_LATENCY must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    logic              owner;
    logic              last_winner;
    logic [LW-1:0]     lat_cnt;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;
    logic [DW/8-1:0]   wmask_q;
    logic              we_q;
    logic [DW-1:0]     rdata_q;
    logic              any_req;
    logic              tie_pick;
    logic              win;

`ifdef MEM_ARB_RR_EN
    assign tie_pick = ~last_winner;
`else
    // last_winner is still tracked but masked out under fixed priority
    assign tie_pick = last_winner & 1'b0;
`endif

    always_comb begin
        any_req = m0_req | m1_req;
        win     = m0_req ? (m1_req ? tie_pick : 1'b0) : 1'b1;
    end

    assign m0_gnt    = (state == IDLE) & any_req & ~win;
    assign m1_gnt    = (state == IDLE) & any_req & win;
    assign m0_done   = (state == DONE) & ~owner;
    assign m1_done   = (state == DONE) & owner;
    assign m0_rdata  = rdata_q;
    assign m1_rdata  = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign mem_we    = (state == ISSUE) & we_q;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_winner <= 1'b1;
            lat_cnt     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        addr_q      <= win ? m1_addr  : m0_addr;
                        wdata_q     <= win ? m1_wdata : m0_wdata;
                        wmask_q     <= win ? m1_wmask : m0_wmask;
                        we_q        <= win ? m1_we    : m0_we;
                        owner       <= win;
                        last_winner <= win;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state <= DONE;
                    end else begin
                        lat_cnt <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LW'(READ_LATENCY - 1)) begin
                        rdata_q <= mem_rdata;
                        state   <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: table of single transactions on a READ_LATENCY=1 instance,
// plus hand sequences for latency, late requests and mid-read reset on a READ_LATENCY=3 instance.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_m0_req = 0, a_m0_we = 0, a_m1_req = 0, a_m1_we = 0;
    logic [31:0] a_m0_addr = 0, a_m0_wdata = 0, a_m1_addr = 0, a_m1_wdata = 0, a_mem_rdata = 0;
    logic [3:0]  a_m0_wmask = 0, a_m1_wmask = 0;
    logic        a_m0_gnt, a_m0_done, a_m1_gnt, a_m1_done, a_mem_we, a_busy;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wmask;

    logic        b_m0_req = 0, b_m0_we = 0, b_m1_req = 0, b_m1_we = 0;
    logic [31:0] b_m0_addr = 0, b_m0_wdata = 0, b_m1_addr = 0, b_m1_wdata = 0, b_mem_rdata = 0;
    logic [3:0]  b_m0_wmask = 0, b_m1_wmask = 0;
    logic        b_m0_gnt, b_m0_done, b_m1_gnt, b_m1_done, b_mem_we, b_busy;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wmask;

    mem_port_arbiter #(.AW(32), .DW(32), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset),
        .m0_req(a_m0_req), .m0_addr(a_m0_addr), .m0_we(a_m0_we), .m0_wdata(a_m0_wdata),
        .m0_wmask(a_m0_wmask), .m0_gnt(a_m0_gnt), .m0_done(a_m0_done), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_addr(a_m1_addr), .m1_we(a_m1_we), .m1_wdata(a_m1_wdata),
        .m1_wmask(a_m1_wmask), .m1_gnt(a_m1_gnt), .m1_done(a_m1_done), .m1_rdata(a_m1_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
        .mem_wmask(a_mem_wmask), .mem_rdata(a_mem_rdata), .busy(a_busy));

    mem_port_arbiter #(.AW(32), .DW(32), .READ_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset),
        .m0_req(b_m0_req), .m0_addr(b_m0_addr), .m0_we(b_m0_we), .m0_wdata(b_m0_wdata),
        .m0_wmask(b_m0_wmask), .m0_gnt(b_m0_gnt), .m0_done(b_m0_done), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_addr(b_m1_addr), .m1_we(b_m1_we), .m1_wdata(b_m1_wdata),
        .m1_wmask(b_m1_wmask), .m1_gnt(b_m1_gnt), .m1_done(b_m1_done), .m1_rdata(b_m1_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata), .busy(b_busy));

    typedef struct {
        logic        r0, we0, r1, we1;
        logic [31:0] a0, wd0, a1, wd1, rd;
        logic [3:0]  wm0, wm1;
        logic        win;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r0, input logic [31:0] a0, input logic we0,
                                input logic [31:0] wd0, input logic [3:0] wm0,
                                input logic r1, input logic [31:0] a1, input logic we1,
                                input logic [31:0] wd1, input logic [3:0] wm1,
                                input logic [31:0] rd, input logic win);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.we0 = we0; v.wd0 = wd0; v.wm0 = wm0;
        v.r1 = r1; v.a1 = a1; v.we1 = we1; v.wd1 = wd1; v.wm1 = wm1;
        v.rd = rd; v.win = win;
        return v;
    endfunction

    vec_t vecs[9];

    initial begin
        vec_t        v;
        logic [31:0] ea, ewd;
        logic [3:0]  ewm;
        logic        ewe, stray;
        int          lat;

        // after reset last_winner=m1, so the first tie goes to m0 in either mode
        vecs[0] = mk(1, 32'h10,  0, 32'h0,        4'h0, 0, 32'h0,   0, 32'h0,        4'h0, 32'hDEADBEEF, 0);
        vecs[1] = mk(0, 32'h0,   0, 32'h0,        4'h0, 1, 32'h20,  1, 32'h12345678, 4'h3, 32'h0,        1);
        vecs[2] = mk(1, 32'h100, 0, 32'h0,        4'h0, 1, 32'h200, 0, 32'h0,        4'h0, 32'h11110000, 0);
        vecs[3] = mk(1, 32'h104, 0, 32'h0,        4'h0, 1, 32'h204, 0, 32'h0,        4'h0, 32'h22220000, RR);
        vecs[4] = mk(1, 32'h108, 0, 32'h0,        4'h0, 1, 32'h208, 0, 32'h0,        4'h0, 32'h33330000, 0);
        vecs[5] = mk(1, 32'h10C, 0, 32'h0,        4'h0, 1, 32'h20C, 0, 32'h0,        4'h0, 32'h44440000, RR);
        vecs[6] = mk(1, 32'h30,  1, 32'hA5A5A5A5, 4'hF, 0, 32'h0,   0, 32'h0,        4'h0, 32'h0,        0);
        vecs[7] = mk(0, 32'h0,   0, 32'h0,        4'h0, 1, 32'h44,  0, 32'h0,        4'h0, 32'hCAFEF00D, 1);
        vecs[8] = mk(1, 32'h50,  1, 32'h0BB0_0BB0, 4'h6, 1, 32'h54, 0, 32'h0,        4'h0, 32'h0,        0);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset busy",   a_busy, 0);
        chk("reset gnt",    {a_m0_gnt, a_m1_gnt}, 0);
        chk("reset done",   {a_m0_done, a_m1_done}, 0);
        chk("reset mem_we", a_mem_we, 0);
        chk("reset addr",   a_mem_addr, 0);
        chk("reset rdata",  a_m0_rdata, 0);

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            @(negedge clk);
            a_m0_req = v.r0; a_m0_addr = v.a0; a_m0_we = v.we0; a_m0_wdata = v.wd0; a_m0_wmask = v.wm0;
            a_m1_req = v.r1; a_m1_addr = v.a1; a_m1_we = v.we1; a_m1_wdata = v.wd1; a_m1_wmask = v.wm1;
            a_mem_rdata = 32'h0;
            #1;
            chk($sformatf("v%0d gnt0", i), a_m0_gnt, !v.win);
            chk($sformatf("v%0d gnt1", i), a_m1_gnt, v.win);
            chk($sformatf("v%0d idle busy", i), a_busy, 0);
            ea  = v.win ? v.a1  : v.a0;
            ewd = v.win ? v.wd1 : v.wd0;
            ewm = v.win ? v.wm1 : v.wm0;
            ewe = v.win ? v.we1 : v.we0;

            @(negedge clk);
            if (v.win) a_m1_req = 1'b0; else a_m0_req = 1'b0;
            a_mem_rdata = v.rd;
            #1;
            chk($sformatf("v%0d issue addr", i),  a_mem_addr, ea);
            chk($sformatf("v%0d issue we", i),    a_mem_we, ewe);
            chk($sformatf("v%0d issue wdata", i), a_mem_wdata, ewd);
            chk($sformatf("v%0d issue wmask", i), a_mem_wmask, ewm);
            chk($sformatf("v%0d issue gnt", i),   {a_m0_gnt, a_m1_gnt}, 0);

            lat = 0;
            stray = 1'b0;
            for (int c = 1; c <= 8 && lat == 0; c++) begin
                @(negedge clk);
                #1;
                if ((v.win ? a_m1_done : a_m0_done)) lat = c;
                if ((v.win ? a_m0_done : a_m1_done) || a_m0_gnt || a_m1_gnt || a_mem_we
                    || a_mem_addr !== ea || !a_busy) stray = 1'b1;
            end
            chk($sformatf("v%0d done latency", i), lat, ewe ? 1 : 2);
            chk($sformatf("v%0d stray activity", i), stray, 0);
            if (!ewe) chk($sformatf("v%0d rdata", i), v.win ? a_m1_rdata : a_m0_rdata, v.rd);
        end
        @(negedge clk);
        a_m0_req = 0; a_m1_req = 0;
        #1;
        chk("post-table addr hold", a_mem_addr, 32'h50);

        // READ_LATENCY=3: sampling point, address hold, late m1 request
        @(negedge clk);
        b_m0_req = 1; b_m0_addr = 32'h40; b_m0_we = 0;
        #1;
        chk("t4 gnt0", b_m0_gnt, 1);
        @(negedge clk);
        b_m0_req = 0; b_mem_rdata = 32'h0;
        #1;
        chk("t4 issue addr", b_mem_addr, 32'h40);
        chk("t4 issue we", b_mem_we, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            b_mem_rdata = (k == 1) ? 32'h11111111 : (k == 2) ? 32'h22222222 : 32'h33333333;
            if (k == 1) begin
                b_m1_req = 1; b_m1_addr = 32'h80; b_m1_we = 0;
            end
            #1;
            chk($sformatf("t4 wait%0d addr", k), b_mem_addr, 32'h40);
            chk($sformatf("t4 wait%0d done", k), b_m0_done, 0);
            chk($sformatf("t6 wait%0d gnt1", k), b_m1_gnt, 0);
        end
        @(negedge clk);
        b_mem_rdata = 32'h44444444;
        #1;
        chk("t4 done", b_m0_done, 1);
        chk("t4 rdata", b_m0_rdata, 32'h33333333);
        chk("t6 gnt1 in done", b_m1_gnt, 0);
        chk("t6 done1 in done", b_m1_done, 0);
        @(negedge clk);
        #1;
        chk("t6 gnt1 in idle", b_m1_gnt, 1);
        chk("t6 idle busy", b_busy, 0);
        @(negedge clk);
        b_m1_req = 0; b_mem_rdata = 32'h0BADF00D;
        #1;
        chk("t6 m1 addr", b_mem_addr, 32'h80);
        repeat (4) @(negedge clk);
        #1;
        chk("t6 m1 done", b_m1_done, 1);
        chk("t6 m1 rdata", b_m1_rdata, 32'h0BADF00D);

        // reset in the middle of a READ_LATENCY=3 read
        @(negedge clk);
        b_m0_req = 1; b_m0_addr = 32'h50;
        #1;
        chk("t5 gnt0", b_m0_gnt, 1);
        @(negedge clk);
        b_m0_req = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        chk("t5 busy after reset", b_busy, 0);
        chk("t5 addr cleared", b_mem_addr, 0);
        chk("t5 rdata cleared", b_m0_rdata, 0);
        stray = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (b_m0_done || b_m1_done || b_busy) stray = 1'b1;
            @(negedge clk);
            #1;
        end
        chk("t5 no done after abort", stray, 0);
        b_m1_req = 1; b_m1_addr = 32'h60; b_m1_we = 0; b_mem_rdata = 32'h600DCAFE;
        #1;
        chk("t5 gnt1", b_m1_gnt, 1);
        @(negedge clk);
        b_m1_req = 0;
        repeat (4) @(negedge clk);
        #1;
        chk("t5 m1 done", b_m1_done, 1);
        chk("t5 m1 rdata", b_m1_rdata, 32'h600DCAFE);
        chk("t5 m0 done", b_m0_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
